// File: rtl/cpu_core_p_pkg.sv
// rtl/cpu_core_p_pkg.sv - shared opcodes, sequencer states and instruction field offsets
package cpu_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_JMP  = 4'd8,
    OP_BEQZ = 4'd9,
    OP_HALT = 4'd15
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_RD1,
    S_RD2,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  // Instruction layout, MSB to LSB: opcode, dst, src2, src1.
  function automatic int instr_width(input int addr_w);
    return OPCODE_W + 3 * addr_w;
  endfunction

  function automatic int opcode_lsb(input int addr_w);
    return 3 * addr_w;
  endfunction

  function automatic int dst_lsb(input int addr_w);
    return 2 * addr_w;
  endfunction

  function automatic int src2_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd7);
  endfunction

endpackage

// File: rtl/cpu_core_p_if.sv
// rtl/cpu_core_p_if.sv - fetch and data-memory req/ack channels of the sequencer
interface cpu_core_p_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int PC_W   = 4
);
  localparam int INSTR_W = 4 + 3 * ADDR_W;

  logic               cmd_req;
  logic [PC_W-1:0]    cmd_addr;
  logic               cmd_ack;
  logic [INSTR_W-1:0] cmd_rdata;

  logic               dmem_req;
  logic               dmem_we;
  logic [ADDR_W-1:0]  dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic               dmem_ack;
  logic [DATA_W-1:0]  dmem_rdata;

  modport master (
    output cmd_req, cmd_addr,
    input  cmd_ack, cmd_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  cmd_req, cmd_addr,
    output cmd_ack, cmd_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/cpu_core_p_alu.sv
// rtl/cpu_core_p_alu.sv - registered ALU; result and zero flag update only when en is high
module cpu_alu_p
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  opcode_t           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              en,
  output logic [DATA_W-1:0] y,
  output logic              zero
);

  logic [DATA_W-1:0] res;
  logic [DATA_W-1:0] y_q, y_d;
  logic              zero_q, zero_d;

  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL:  res = a << b[3:0];
      OP_SHR:  res = a >> b[3:0];
      default: res = '0;
    endcase
    y_d    = y_q;
    zero_d = zero_q;
    if (en) begin
      y_d    = res;
      zero_d = (res == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      zero_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      zero_q <= zero_d;
    end
  end

  assign y    = y_q;
  assign zero = zero_q;

endmodule

// File: rtl/cpu_core_p.sv
// rtl/cpu_core_p.sv - multi-cycle fetch/read/execute/writeback sequencer with req/ack memories
module cpu_core_p
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int PC_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  cpu_core_p_if.master    bus,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            zero_flag
);

  localparam int INSTR_W  = instr_width(ADDR_W);
  localparam int OP_LSB   = opcode_lsb(ADDR_W);
  localparam int DST_LSB  = dst_lsb(ADDR_W);
  localparam int SRC2_LSB = src2_lsb(ADDR_W);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0]  op1_q, op1_d;
  logic [DATA_W-1:0]  op2_q, op2_d;
  logic               cmd_req_q, cmd_req_d;
  logic               dmem_req_q, dmem_req_d;

  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  dst, src2, src1;
  logic               cmd_done, dmem_done;
  logic [DATA_W-1:0]  alu_y;
  logic               alu_zero;
  logic [ADDR_W-1:0]  dmem_addr;

  assign opcode = instr_q[OP_LSB +: OPCODE_W];
  assign dst    = instr_q[DST_LSB +: ADDR_W];
  assign src2   = instr_q[SRC2_LSB +: ADDR_W];
  assign src1   = instr_q[0 +: ADDR_W];

  // Acks only count against a request we are actually holding.
  assign cmd_done  = cmd_req_q & bus.cmd_ack;
  assign dmem_done = dmem_req_q & bus.dmem_ack;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    case (state_q)
      S_FETCH: begin
        if (cmd_done) begin
          instr_d = bus.cmd_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (opcode == OP_JMP) begin
          pc_d    = PC_W'({dst, src2, src1});
          state_d = S_FETCH;
        end else if ((opcode == OP_BEQZ) || is_alu_op(opcode)) begin
          state_d = S_RD1;
        end else begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_RD1: begin
        if (dmem_done) begin
          op1_d = bus.dmem_rdata;
          if (opcode == OP_BEQZ) begin
            pc_d    = (bus.dmem_rdata == '0) ? PC_W'(dst) : pc_q + 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_RD2;
          end
        end
      end
      S_RD2: begin
        if (dmem_done) begin
          op2_d   = bus.dmem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        if (dmem_done) begin
          pc_d    = pc_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Requests follow the next state but drop for one cycle after an ack,
    // which gives the idle gap between the back-to-back RD1/RD2 reads.
    cmd_req_d  = (state_d == S_FETCH) && !cmd_done;
    dmem_req_d = (state_d inside {S_RD1, S_RD2, S_WB}) && !dmem_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      instr_q    <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      cmd_req_q  <= 1'b0;
      dmem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      cmd_req_q  <= cmd_req_d;
      dmem_req_q <= dmem_req_d;
    end
  end

  cpu_alu_p #(.DATA_W(DATA_W)) u_alu (
    .clk  (clk),
    .rst  (rst),
    .op   (opcode_t'(opcode)),
    .a    (op1_q),
    .b    (op2_q),
    .en   (state_q == S_EXEC),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_comb begin
    dmem_addr = '0;
    case (state_q)
      S_RD1:   dmem_addr = src1;
      S_RD2:   dmem_addr = src2;
      S_WB:    dmem_addr = dst;
      default: dmem_addr = '0;
    endcase
  end

  assign bus.cmd_req    = cmd_req_q;
  assign bus.cmd_addr   = pc_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = (state_q == S_WB);
  assign bus.dmem_addr  = dmem_addr;
  assign bus.dmem_wdata = (state_q == S_WB) ? alu_y : '0;

  assign pc        = pc_q;
  assign halted    = (state_q == S_HALT);
  assign zero_flag = alu_zero;

endmodule

// File: tb/tb_cpu_core_p.sv
// tb/tb_cpu_core_p.sv - vector table, directed corner sequences and random programs vs reference model
module tb_cpu_core_p;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pc;
  logic       halted;
  logic       zero_flag;

  always #5 clk = ~clk;

  cpu_core_p_if #(.DATA_W(16), .ADDR_W(4), .PC_W(4)) bus ();

  cpu_core_p #(.DATA_W(16), .ADDR_W(4), .PC_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .pc        (pc),
    .halted    (halted),
    .zero_flag (zero_flag)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] imem [16];
  logic [15:0] dmem_init [16];
  logic [15:0] dmem [16];
  int cmd_max  = 0;
  int dmem_max = 0;
  int late_req = 0;
  int late_done = 0;

  int cyc = 0;
  logic [3:0]  obs_fetch[$];
  int          obs_fetch_cyc[$];
  logic [19:0] obs_wr[$];
  int n_rd = 0;
  int unstable_c = 0;
  int unstable_d = 0;

  logic [3:0]  exp_fetch[$];
  logic [19:0] exp_wr[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: ack after a random wait while req is held.
  initial begin : cmd_resp
    int cnt;
    int dly;
    logic [3:0] a0;
    cnt = 0; dly = 0; a0 = '0;
    bus.cmd_ack = 1'b0;
    bus.cmd_rdata = '0;
    forever begin
      @(negedge clk);
      bus.cmd_ack = 1'b0;
      if (rst) begin
        obs_fetch.delete();
        obs_fetch_cyc.delete();
        unstable_c = 0;
        cnt = 0;
      end else if (bus.cmd_req) begin
        if (cnt == 0) begin
          a0 = bus.cmd_addr;
          dly = $urandom_range(0, cmd_max);
        end else if (bus.cmd_addr !== a0) begin
          unstable_c++;
        end
        if (cnt == dly) begin
          bus.cmd_ack = 1'b1;
          bus.cmd_rdata = imem[bus.cmd_addr];
          obs_fetch.push_back(bus.cmd_addr);
          obs_fetch_cyc.push_back(cyc);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Data memory: same handshake; can also inject an ack with no request pending.
  initial begin : dmem_resp
    int cnt;
    int dly;
    logic [3:0] a0;
    logic we0;
    cnt = 0; dly = 0; a0 = '0; we0 = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.dmem_ack = 1'b0;
      if (rst) begin
        for (int i = 0; i < 16; i++) dmem[i] = dmem_init[i];
        obs_wr.delete();
        n_rd = 0;
        unstable_d = 0;
        cnt = 0;
      end else if (late_req != late_done) begin
        late_done = late_req;
        if (!bus.dmem_req) bus.dmem_ack = 1'b1;
      end else if (bus.dmem_req) begin
        if (cnt == 0) begin
          a0 = bus.dmem_addr;
          we0 = bus.dmem_we;
          dly = $urandom_range(0, dmem_max);
        end else if (bus.dmem_addr !== a0 || bus.dmem_we !== we0) begin
          unstable_d++;
        end
        if (cnt == dly) begin
          bus.dmem_ack = 1'b1;
          cnt = 0;
          if (bus.dmem_we) begin
            dmem[bus.dmem_addr] = bus.dmem_wdata;
            obs_wr.push_back({bus.dmem_addr, bus.dmem_wdata});
          end else begin
            bus.dmem_rdata = dmem[bus.dmem_addr];
            n_rd++;
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] fetch_at(input int k);
    return (obs_fetch.size() > k) ? 32'(obs_fetch[k]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wr_at(input int k);
    return (obs_wr.size() > k) ? 32'(obs_wr[k]) : 32'hDEAD_BEEF;
  endfunction

  task automatic wait_halt(input int budget);
    int i;
    for (i = 0; i < budget && !halted; i++) tick();
    check("halt_within_budget", 32'(halted), 32'd1);
  endtask

  task automatic wait_fetches(input int n, input int budget);
    int i;
    for (i = 0; i < budget && obs_fetch.size() < n; i++) tick();
    check("fetches_within_budget", 32'(obs_fetch.size() >= n), 32'd1);
  endtask

  function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    case (op)
      4'd1: return a + b;
      4'd2: return a - b;
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return a ^ b;
      4'd6: return a << b[3:0];
      4'd7: return a >> b[3:0];
      default: return 16'h0;
    endcase
  endfunction

  // Architectural model: one instruction per step over its own copy of data memory.
  task automatic run_model(input int steps, output int nw_before_last);
    logic [15:0] m [16];
    logic [3:0]  mpc;
    logic [15:0] ins, r;
    logic [11:0] tgt;
    logic [3:0]  op, d, s2, s1;
    for (int i = 0; i < 16; i++) m[i] = dmem_init[i];
    mpc = 4'd0;
    exp_fetch.delete();
    exp_wr.delete();
    nw_before_last = 0;
    for (int k = 0; k < steps; k++) begin
      if (k == steps - 1) nw_before_last = exp_wr.size();
      exp_fetch.push_back(mpc);
      ins = imem[mpc];
      op = ins[15:12]; d = ins[11:8]; s2 = ins[7:4]; s1 = ins[3:0];
      if (op >= 4'd1 && op <= 4'd7) begin
        r = alu_ref(op, m[s1], m[s2]);
        m[d] = r;
        exp_wr.push_back({d, r});
        mpc = mpc + 4'd1;
      end else if (op == 4'd8) begin
        tgt = ins[11:0];
        mpc = tgt[3:0];
      end else if (op == 4'd9) begin
        mpc = (m[s1] == 16'h0) ? d : mpc + 4'd1;
      end else begin
        mpc = mpc + 4'd1;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      imem[i] = 16'hF000;
      dmem_init[i] = 16'h0;
    end
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic        z;
  } alu_vec_t;

  alu_vec_t vecs[10];

  initial begin : main
    int cnt_req;
    int nw;
    int budget;
    bit seen;

    vecs[0] = '{"add",      4'd1, 16'h0005, 16'h0007, 16'h000C, 1'b0};
    vecs[1] = '{"sub_wrap", 4'd2, 16'h0003, 16'h0005, 16'hFFFE, 1'b0};
    vecs[2] = '{"sub_eq",   4'd2, 16'h0009, 16'h0009, 16'h0000, 1'b1};
    vecs[3] = '{"and",      4'd3, 16'hF0F0, 16'h3CC3, 16'h30C0, 1'b0};
    vecs[4] = '{"or",       4'd4, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0};
    vecs[5] = '{"xor_eq",   4'd5, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1};
    vecs[6] = '{"shl",      4'd6, 16'h0001, 16'h0013, 16'h0008, 1'b0};
    vecs[7] = '{"shr",      4'd7, 16'h8000, 16'h000F, 16'h0001, 1'b0};
    vecs[8] = '{"add_wrap", 4'd1, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
    vecs[9] = '{"shr_hi",   4'd7, 16'h1234, 16'h0010, 16'h1234, 1'b0};

    clear_mem();
    tick();
    tick();
    check("rst_cmd_req",    32'(bus.cmd_req), 32'd0);
    check("rst_dmem_req",   32'(bus.dmem_req), 32'd0);
    check("rst_dmem_we",    32'(bus.dmem_we), 32'd0);
    check("rst_dmem_addr",  32'(bus.dmem_addr), 32'd0);
    check("rst_dmem_wdata", 32'(bus.dmem_wdata), 32'd0);
    check("rst_pc",         32'(pc), 32'd0);
    check("rst_halted",     32'(halted), 32'd0);
    check("rst_zero_flag",  32'(zero_flag), 32'd0);
    rst = 1'b0;

    // ALU vectors with zero-wait memories; instruction ALU dst=3, src2=2, src1=1, then HALT.
    for (int v = 0; v < 10; v++) begin
      clear_mem();
      imem[0] = {vecs[v].op, 4'd3, 4'd2, 4'd1};
      dmem_init[1] = vecs[v].a;
      dmem_init[2] = vecs[v].b;
      dmem_init[3] = 16'hDEAD;
      cmd_max = 0; dmem_max = 0;
      apply_reset();
      wait_halt(60);
      check({vecs[v].name, "_nwrites"}, 32'(obs_wr.size()), 32'd1);
      check({vecs[v].name, "_write"}, wr_at(0), 32'({4'd3, vecs[v].y}));
      check({vecs[v].name, "_zero"}, 32'(zero_flag), 32'(vecs[v].z));
      check({vecs[v].name, "_pc"}, 32'(pc), 32'd1);
      check({vecs[v].name, "_latency"},
            (obs_fetch_cyc.size() > 1) ? 32'(obs_fetch_cyc[1] - obs_fetch_cyc[0]) : 32'hDEAD_BEEF,
            32'd7);
    end

    // BEQZ dst=9 src1=4, taken and not taken.
    for (int t = 0; t < 2; t++) begin
      clear_mem();
      imem[0] = 16'h9904;
      dmem_init[4] = (t == 0) ? 16'h0000 : 16'h0001;
      apply_reset();
      wait_halt(40);
      check((t == 0) ? "beqz_taken_target" : "beqz_fall_target", fetch_at(1), (t == 0) ? 32'd9 : 32'd1);
      check("beqz_no_write", 32'(obs_wr.size()), 32'd0);
    end

    // JMP to 15, NOP there wraps the pc to 0.
    clear_mem();
    imem[0]  = 16'h800F;
    imem[15] = 16'h0000;
    apply_reset();
    wait_fetches(4, 40);
    check("jmp_target", fetch_at(1), 32'd15);
    check("pc_wrap",    fetch_at(2), 32'd0);
    check("loop_again", fetch_at(3), 32'd15);

    // HALT at pc 0: no further fetch for 20 cycles.
    clear_mem();
    apply_reset();
    wait_halt(20);
    cnt_req = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.cmd_req) cnt_req++;
    end
    check("halt_no_req",  32'(cnt_req), 32'd0);
    check("halt_fetches", 32'(obs_fetch.size()), 32'd1);
    check("halt_pc",      32'(pc), 32'd0);
    check("halt_flag",    32'(halted), 32'd1);

    // Reset while the second operand read is outstanding.
    clear_mem();
    imem[0] = {4'd1, 4'd3, 4'd2, 4'd1};
    dmem_init[1] = 16'd5;
    dmem_init[2] = 16'd7;
    dmem_max = 3;
    apply_reset();
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (n_rd == 1 && bus.dmem_req === 1'b1) seen = 1'b1;
    end
    check("rd2_reached", 32'(seen), 32'd1);
    rst = 1'b1;
    tick();
    check("midrst_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("midrst_pc",       32'(pc), 32'd0);
    rst = 1'b0;
    late_req++;
    wait_halt(80);
    check("midrst_refetch", fetch_at(0), 32'd0);
    check("midrst_nwrites", 32'(obs_wr.size()), 32'd1);
    check("midrst_write",   wr_at(0), 32'h3000C);

    // Random programs with 0-5 cycle waits against the architectural model.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 16; i++) begin
        imem[i] = 16'($urandom);
        imem[i][15:12] = 4'($urandom_range(0, 14));
        dmem_init[i] = (i % 2 == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
      end
      cmd_max = 5; dmem_max = 5;
      run_model(40, nw);
      apply_reset();
      budget = 2500;
      wait_fetches(40, budget);
      for (int k = 0; k < 40; k++)
        check($sformatf("rand%0d_fetch%0d", r, k), fetch_at(k), 32'(exp_fetch[k]));
      check($sformatf("rand%0d_nwrites", r), 32'(obs_wr.size()), 32'(nw));
      for (int k = 0; k < nw; k++)
        check($sformatf("rand%0d_write%0d", r, k), wr_at(k), 32'(exp_wr[k]));
      check($sformatf("rand%0d_cmd_stable", r), 32'(unstable_c), 32'd0);
      check($sformatf("rand%0d_dmem_stable", r), 32'(unstable_d), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

endmodule
